// File: rtl/register_file_initiator.sv
// Register-file bus initiator: accepts one command at a time, drives a single
// register-file access, and reports read data or a timeout on a response port.
module register_file_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rf_write_enable,
    output logic              rf_read_enable,
    output logic [1:0]        rf_address,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data,
    input  logic              rf_ready,
    output logic [7:0]        timeout_count
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Wait-counter value at which the final BUSY edge without rf_ready aborts.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    logic [7:0]          r_wait;
    logic                r_we;
    logic                r_re;
    logic [1:0]          r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rspValid;
    logic [DATA_W-1:0]   r_rspRdata;
    logic                r_rspError;
    logic [7:0]          r_timeouts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait     <= 8'd0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_addr     <= 2'd0;
            r_wdata    <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspError <= 1'b0;
            r_timeouts <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_write ? cmd_wdata : '0;
                        r_we    <= cmd_write;
                        r_re    <= !cmd_write;
                        r_wait  <= 8'd0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (rf_ready) begin
                        r_we       <= 1'b0;
                        r_re       <= 1'b0;
                        r_rspRdata <= r_re ? rf_read_data : '0;
                        r_rspError <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_state    <= RESP;
                    end else if (r_wait == WAIT_LAST) begin
                        r_we       <= 1'b0;
                        r_re       <= 1'b0;
                        r_rspRdata <= '0;
                        r_rspError <= 1'b1;
                        r_rspValid <= 1'b1;
                        if (r_timeouts != 8'hFF) begin
                            r_timeouts <= r_timeouts + 8'd1;
                        end
                        r_state    <= RESP;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                RESP: begin
                    // A new command is never taken on the handshake edge itself.
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_rspError <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready       = (r_state == IDLE);
    assign rf_write_enable = r_we;
    assign rf_read_enable  = r_re;
    assign rf_address      = r_addr;
    assign rf_write_data   = r_wdata;
    assign rsp_valid       = r_rspValid;
    assign rsp_rdata       = r_rspRdata;
    assign rsp_error       = r_rspError;
    assign timeout_count   = r_timeouts;

endmodule

// File: tb/tb_register_file_initiator.sv
// Self-checking bench for register_file_initiator: a transaction-level model
// predicts every output each cycle, plus literal checks for key scenarios.
module tb_register_file_initiator;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rf_write_enable;
    logic        rf_read_enable;
    logic [1:0]  rf_address;
    logic [31:0] rf_write_data;
    logic [31:0] rf_read_data;
    logic        rf_ready;
    logic [7:0]  timeout_count;

    register_file_initiator #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .DATA_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .rf_write_enable(rf_write_enable),
        .rf_read_enable(rf_read_enable),
        .rf_address(rf_address),
        .rf_write_data(rf_write_data),
        .rf_read_data(rf_read_data),
        .rf_ready(rf_ready),
        .timeout_count(timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int enCycles = 0;
    bit checkOn  = 1'b0;

    // Expected outputs, maintained by the transaction driver from the protocol rules.
    logic        expCmdReady;
    logic        expWe;
    logic        expRe;
    logic [1:0]  expAddr;
    logic [31:0] expWdata;
    logic        expValid;
    logic [31:0] expRdata;
    logic        expErr;
    logic [7:0]  expTo;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        expCmdReady = 1'b1;
        expWe       = 1'b0;
        expRe       = 1'b0;
        expAddr     = 2'd0;
        expWdata    = 32'd0;
        expValid    = 1'b0;
        expRdata    = 32'd0;
        expErr      = 1'b0;
        expTo       = 8'd0;
    endtask

    // Compare every output against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("cmd_ready",       32'(cmd_ready),       32'(expCmdReady));
            checkOutput("rf_write_enable", 32'(rf_write_enable), 32'(expWe));
            checkOutput("rf_read_enable",  32'(rf_read_enable),  32'(expRe));
            checkOutput("rf_address",      32'(rf_address),      32'(expAddr));
            checkOutput("rf_write_data",   rf_write_data,        expWdata);
            checkOutput("rsp_valid",       32'(rsp_valid),       32'(expValid));
            checkOutput("rsp_rdata",       rsp_rdata,            expRdata);
            checkOutput("rsp_error",       32'(rsp_error),       32'(expErr));
            checkOutput("timeout_count",   32'(timeout_count),   32'(expTo));
        end
        if (rf_write_enable || rf_read_enable) enCycles++;
    end

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // One full access: delay = BUSY edges with rf_ready low before it rises
    // (>= TIMEOUT means never), hold = cycles rsp_ready stays low in RESP,
    // pend = keep a write to addr 3 pending on the command port during RESP.
    task automatic applyStimulus(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                                 input int delay, input logic [31:0] rdata, input int hold,
                                 input bit pend);
        int  busyEdges;
        bit  timedOut;
        timedOut  = (delay >= TIMEOUT);
        busyEdges = timedOut ? TIMEOUT : delay + 1;
        enCycles  = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        rf_ready  = 1'b0;
        rsp_ready = 1'b0;
        stepEdge();
        expCmdReady = 1'b0;
        expWe       = wr;
        expRe       = !wr;
        expAddr     = addr;
        expWdata    = wr ? wdata : 32'd0;
        for (int k = 1; k <= busyEdges; k++) begin
            cmd_valid    = 1'($urandom_range(0, 1));
            cmd_write    = 1'($urandom_range(0, 1));
            cmd_addr     = 2'($urandom_range(0, 3));
            cmd_wdata    = $urandom;
            rf_ready     = (k == delay + 1);
            rf_read_data = (k == delay + 1) ? rdata : $urandom;
            stepEdge();
        end
        expWe    = 1'b0;
        expRe    = 1'b0;
        expValid = 1'b1;
        expErr   = timedOut;
        expRdata = (!timedOut && !wr) ? rdata : 32'd0;
        if (timedOut && expTo != 8'hFF) expTo = expTo + 8'd1;
        rf_ready     = 1'b1;
        rf_read_data = $urandom;
        for (int k = 0; k < hold; k++) begin
            if (pend) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = 2'd3;
                cmd_wdata = 32'hA5A5A5A5;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_wdata = $urandom;
            end
            stepEdge();
        end
        if (!pend) cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        stepEdge();
        rsp_ready   = 1'b0;
        rf_ready    = 1'b0;
        expValid    = 1'b0;
        expErr      = 1'b0;
        expCmdReady = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = 2'd0;
        cmd_wdata    = 32'd0;
        rsp_ready    = 1'b0;
        rf_read_data = 32'd0;
        rf_ready     = 1'b0;
        modelReset();
        #3;
        checkOutput("reset cmd_ready",     32'(cmd_ready),     32'd1);
        checkOutput("reset rsp_valid",     32'(rsp_valid),     32'd0);
        checkOutput("reset timeout_count", 32'(timeout_count), 32'd0);
        #9 reset = 1'b0;
        stepEdge();
        checkOn = 1'b1;
        stepEdge();

        // Write with immediate ready.
        applyStimulus(1'b1, 2'd2, 32'hDEADBEEF, 0, 32'd0, 0, 1'b0);
        checkOutput("write enable cycles", 32'(enCycles), 32'd1);
        checkOutput("write rsp_rdata",     rsp_rdata,     32'd0);

        // Read with three wait cycles.
        applyStimulus(1'b0, 2'd1, 32'hFFFFFFFF, 3, 32'h12345678, 0, 1'b0);
        checkOutput("read enable cycles", 32'(enCycles), 32'd4);
        checkOutput("read rsp_rdata",     rsp_rdata,     32'h12345678);

        // Timeout with rf_ready held low.
        applyStimulus(1'b0, 2'd0, 32'd0, NEVER, 32'h0BADF00D, 2, 1'b0);
        checkOutput("timeout enable cycles", 32'(enCycles),      32'd16);
        checkOutput("timeout count",         32'(timeout_count), 32'd1);

        // Response backpressure with a pending command, then that command.
        applyStimulus(1'b0, 2'd3, 32'd0, 1, 32'hCAFEF00D, 5, 1'b1);
        checkOutput("backpressure rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        applyStimulus(1'b1, 2'd3, 32'hA5A5A5A5, 2, 32'd0, 1, 1'b0);
        checkOutput("pending write address", 32'(rf_address), 32'd3);

        // Mixed accesses, including ready on the last BUSY edge before timeout.
        applyStimulus(1'b0, 2'd0, 32'd0, TIMEOUT - 1, 32'h55AA33CC, 0, 1'b0);
        applyStimulus(1'b1, 2'd1, 32'h00000001, 5, 32'd0, 3, 1'b0);
        applyStimulus(1'b0, 2'd2, 32'd0, 0, 32'h80000000, 1, 1'b0);
        checkOutput("last-edge timeout count", 32'(timeout_count), 32'd1);

        // Reset in the middle of a read.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 2'd2;
        rf_ready  = 1'b0;
        stepEdge();
        cmd_valid   = 1'b0;
        expCmdReady = 1'b0;
        expRe       = 1'b1;
        expAddr     = 2'd2;
        expWdata    = 32'd0;
        stepEdge();
        stepEdge();
        checkOn = 1'b0;
        #1 reset = 1'b1;
        #1;
        checkOutput("mid-reset read_enable",   32'(rf_read_enable),  32'd0);
        checkOutput("mid-reset write_enable",  32'(rf_write_enable), 32'd0);
        checkOutput("mid-reset rsp_valid",     32'(rsp_valid),       32'd0);
        checkOutput("mid-reset timeout_count", 32'(timeout_count),   32'd0);
        checkOutput("mid-reset cmd_ready",     32'(cmd_ready),       32'd1);
        modelReset();
        @(posedge clk);
        #4 reset = 1'b0;
        stepEdge();
        checkOn = 1'b1;
        applyStimulus(1'b1, 2'd1, 32'h13579BDF, 1, 32'd0, 0, 1'b0);

        // Saturation of the timeout counter.
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b0, 2'(i), 32'd0, NEVER, 32'd0, 0, 1'b0);
        end
        checkOutput("saturated timeout_count", 32'(timeout_count), 32'd255);

        stepEdge();
        checkOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_initiator.md
Name: register_file_initiator

Overview:
- Bus initiator that drives the 4-entry, 32-bit register file protocol from the requester side: write_enable/read_enable, address, write_data out; read_data/ready in.
- Accepts single commands on a valid/ready command port and drives one register file access per command.
- Waits for the responder's ready, with a timeout, and returns read data plus an error flag on a valid/ready response port.
- Sits between a control/CSR master and the register file DUT. Used as a synthesizable replacement for the testbench driver.

Parameters:
- TIMEOUT_CYCLES, 16, number of BUSY-state clock edges without rf_ready before the access is aborted; legal range 1..255.
- DATA_W, 32, data width of write_data, read_data, cmd_wdata and rsp_rdata.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  2  register index.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_error  out  1  access timed out.
- rf_write_enable  out  1  to the responder's write_enable.
- rf_read_enable  out  1  to the responder's read_enable.
- rf_address  out  2  to the responder's address.
- rf_write_data  out  DATA_W  to the responder's write_data.
- rf_read_data  in  DATA_W  from the responder's read_data.
- rf_ready  in  1  from the responder's ready.
- timeout_count  out  8  saturating count of timed-out accesses.

Behaviour:
- Reset: asynchronous, active-high. All outputs are registered and clear to 0, except cmd_ready, which is 1 because the FSM enters IDLE. The timeout counter clears.
- Reset mid-transaction aborts the access immediately; enables drop asynchronously and no response is produced.
- FSM states: IDLE, BUSY, RESP.
- cmd_ready = (state == IDLE); it is combinational from state only and never depends on cmd_valid.
- IDLE:
  - On an edge with cmd_valid && cmd_ready: latch rf_address = cmd_addr and rf_write_data = cmd_wdata (writes; reads drive 0).
  - Set rf_write_enable = cmd_write and rf_read_enable = !cmd_write. Exactly one enable is high.
  - Clear the wait counter; go to BUSY.
- BUSY: rf_address, rf_write_data and the enable hold stable every cycle. At each edge:
  - rf_ready = 1: drop both enables. Capture rsp_rdata = rf_read_data for reads, 0 for writes. Set rsp_error = 0, rsp_valid = 1; go to RESP.
  - Else if wait counter == TIMEOUT_CYCLES-1: drop both enables. Set rsp_rdata = 0, rsp_error = 1, rsp_valid = 1. Increment timeout_count, saturating at 255. Go to RESP.
  - Else: increment the wait counter.
- RESP: rsp_valid, rsp_rdata and rsp_error are held stable until an edge with rsp_ready = 1. That edge clears rsp_valid and rsp_error and returns to IDLE.
  - No new command is accepted in the same edge, so a new access starts at the earliest 1 cycle later.
- Latency:
  - Command accept edge E0: enables are visible after E0.
  - rf_ready high before edge E1: rsp_valid is high after E1, giving 1-cycle minimum access latency.
  - Back-to-back throughput is one command per 3 cycles minimum.
- rf_ready sampled while in IDLE or RESP is ignored.
- rf_address and rf_write_data keep their last values outside BUSY, except write_data, which is 0 on reads.
- Wait counter width is 8 bits. A timeout occurs after exactly TIMEOUT_CYCLES BUSY edges with rf_ready low.
- cmd_valid may drop without acceptance; there is no requirement on command stability.

Test Plan:
- Write: cmd addr 2, wdata 0xDEADBEEF, rf_ready high on the first BUSY edge -> rf_write_enable high for exactly 1 cycle with rf_address = 2 and rf_write_data = 0xDEADBEEF; rsp_valid 1 cycle after accept; rsp_rdata = 0; rsp_error = 0.
- Read: addr 1, responder returns 0x12345678 with rf_ready after 3 wait cycles -> rf_read_enable high for 4 cycles; rsp_rdata = 0x12345678; rsp_error = 0.
- Timeout: TIMEOUT_CYCLES = 16, rf_ready held low -> enables drop after the 16th BUSY edge; rsp_error = 1; rsp_rdata = 0; timeout_count increments from 0 to 1.
- Backpressure: rsp_ready low for 5 cycles after a read -> rsp_valid and rsp_rdata stable throughout; cmd_ready stays 0; a pending cmd_valid is accepted 1 cycle after the rsp_ready handshake.
- Reset during BUSY: assert reset mid-read -> enables, rsp_valid and timeout_count read 0 immediately, before the next edge; after release, cmd_ready = 1 and a new write completes normally.
- Saturation: 260 consecutive timeouts -> timeout_count holds at 255.
